// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debounce stage.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 3;

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button-side bundle: raw button in, toggle pulse and debounced level out.
interface btn_debounce_pulse_if;

    logic btn_in;
    logic t_pulse;
    logic btn_level;

    modport master (
        output btn_in,
        input  t_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        output t_pulse,
        output btn_level
    );

endinterface

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic sync_d, sync_q;

    always_comb begin
        s1_d   = d;
        sync_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button synchroniser + debouncer emitting a one-cycle toggle pulse per press.
// Define BTN_RELEASE_PULSE_EN to also pulse on each accepted release.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_pulse_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync;
    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             t_pulse_d, t_pulse_q;
    logic             btn_level_d, btn_level_q;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_pulse_q   <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_pulse_q   <= t_pulse_d;
            btn_level_q <= btn_level_d;
        end
    end

    // The first differing sample already counts as one, hence cnt starts at 1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        t_pulse_d   = 1'b0;
        btn_level_d = btn_level_q;
        unique case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    t_pulse_d   = 1'b1;
                    btn_level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    btn_level_d = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                    t_pulse_d   = 1'b1;
`else
                    t_pulse_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.t_pulse   = t_pulse_q;
    assign bus.btn_level = btn_level_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with a downstream T flip-flop model.
module tb_btn_debounce_pulse;

`ifdef BTN_RELEASE_PULSE_EN
    localparam bit REL_PULSE = 1'b1;
`else
    localparam bit REL_PULSE = 1'b0;
`endif

    logic clk;
    logic rst;
    logic tq;
    bit   exp_tq;
    int   checks;
    int   failures;
    int   pulse_cnt;

    btn_debounce_pulse_if bus ();

    btn_debounce_pulse dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream T flip-flop driven by the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tq <= 1'b0;
        else if (bus.t_pulse)
            tq <= ~tq;
    end

    always @(negedge clk) begin
        if (bus.t_pulse)
            pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges counted from E0, the first edge after the input settles.
    task automatic watch(input string tag, input bit lvl);
        bit exp_p;
        bit exp_l;
        bit fires;
        int base;
        fires = lvl ? 1'b1 : REL_PULSE;
        base  = pulse_cnt;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_p = fires && (e == 5);
            exp_l = (e >= 5) ? lvl : ~lvl;
            check($sformatf("%s_pulse_e%0d", tag, e), 32'(bus.t_pulse), 32'(exp_p));
            check($sformatf("%s_level_e%0d", tag, e), 32'(bus.btn_level), 32'(exp_l));
            if (exp_p)
                exp_tq = ~exp_tq;
            if (e == 6)
                check($sformatf("%s_tq", tag), 32'(tq), 32'(exp_tq));
        end
        check($sformatf("%s_npulse", tag), 32'(pulse_cnt - base), 32'(fires));
    endtask

    task automatic level_change(input string tag, input bit lvl);
        bus.btn_in = lvl;
        watch(tag, lvl);
    endtask

    initial begin
        int base;
        checks    = 0;
        failures  = 0;
        pulse_cnt = 0;
        exp_tq    = 1'b0;

        rst        = 1'b1;
        bus.btn_in = 1'b1;
        #2;
        check("rst_pulse", 32'(bus.t_pulse), 32'd0);
        check("rst_level", 32'(bus.btn_level), 32'd0);
        bus.btn_in = 1'b0;
        #1 rst = 1'b0;
        repeat (3) tick();

        level_change("press1", 1'b1);
        base = pulse_cnt;
        repeat (10) tick();
        check("hold_level", 32'(bus.btn_level), 32'd1);
        check("hold_norepeat", 32'(pulse_cnt - base), 32'd0);

        level_change("rel1", 1'b0);
        repeat (3) tick();

        base = pulse_cnt;
        bus.btn_in = 1'b1;
        repeat (2) tick();
        bus.btn_in = 1'b0;
        tick();
        bus.btn_in = 1'b1;
        repeat (2) tick();
        bus.btn_in = 1'b0;
        repeat (8) tick();
        check("bounce_npulse", 32'(pulse_cnt - base), 32'd0);
        check("bounce_level", 32'(bus.btn_level), 32'd0);

        level_change("press2", 1'b1);
        repeat (3) tick();
        level_change("rel2", 1'b0);
        repeat (3) tick();
        level_change("press3", 1'b1);
        check("chain_q", 32'(tq), 32'(exp_tq));

        #3 rst = 1'b1;
        exp_tq = 1'b0;
        #1;
        check("async_level", 32'(bus.btn_level), 32'd0);
        check("async_pulse", 32'(bus.t_pulse), 32'd0);
        check("async_tq", 32'(tq), 32'd0);
        bus.btn_in = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();

        base = pulse_cnt;
        bus.btn_in = 1'b1;
        repeat (4) tick();
        check("midcnt_level", 32'(bus.btn_level), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midcnt_rst_level", 32'(bus.btn_level), 32'd0);
        tick();
        rst = 1'b0;
        check("midcnt_npulse", 32'(pulse_cnt - base), 32'd0);
        watch("midcnt", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
